// File: rtl/cbus_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_ram_responder_pkg
//  Purpose  : Shared types and constants for the CBus RAM responder:
//             CBus request/response structs, burst-length and size encodings,
//             responder FSM state enum, RAM index and latency counter widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cbus_ram_responder_pkg;

  // Burst length: beats = encoding + 1
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
    MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
    MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
    MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
  } cbus_len_e;

  // Access size; carried on the bus but not used by the RAM responder
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } cbus_size_e;

  typedef struct packed {
    logic       valid;
    logic       is_write;
    cbus_size_e size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_e   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_MEM_WORDS = 4096;
  localparam int unsigned RAM_IDX_W         = $clog2(DEFAULT_MEM_WORDS);
  localparam int unsigned LAT_W             = 4;

endpackage
`default_nettype wire

// File: rtl/cbus_ram_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_ram_responder_if
//  Purpose  : CBus request/response bundle between a requester (CPU side)
//             and a responder.
//  Signals  : creq  - request struct, driven by the master
//             cresp - response struct, driven by the slave
//  Modports : master (drives creq), slave (drives cresp)
//  Revision : 1.0 - initial release
// ============================================================================
interface cbus_ram_responder_if;
  import cbus_ram_responder_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);

endinterface
`default_nettype wire

// File: rtl/cbus_ram_responder_array.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_ram_responder_array
//  Purpose  : Single-port DEPTH x 32 RAM with 4 byte-write lanes and a
//             registered read port. The read register only updates on a
//             read access, so it holds its value between reads.
//  Ports    : clk       in  clock
//             reset     in  sync active-high, clears the read register only
//             en_i      in  access enable
//             we_i      in  write (1) / read (0) when enabled
//             strobe_i  in  byte-lane write enables
//             addr_i    in  word index
//             wdata_i   in  write data
//             rdata_o   out registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module cbus_ram_responder_array #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [3:0]       strobe_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage is never reset: contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (strobe_i[lane]) begin
          mem_q[addr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cbus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_ram_responder
//  Purpose  : CBus responder serving single/burst reads and writes from an
//             internal byte-writable RAM with configurable start latency.
//             Once a burst starts, one beat is returned every cycle.
//  Ports    : clk        in  rising-edge clock
//             reset      in  sync active-high reset
//             cbus       if  slave modport: creq in, cresp out
//             proto_err  out sticky flag, requester dropped valid mid-transaction
//  Revision : 1.0 - initial release
// ============================================================================
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                clk,
  input  logic                reset,
  cbus_ram_responder_if.slave cbus,
  output logic                proto_err
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  state_e           state_q;
  logic [IDX_W-1:0] base_q;
  logic [3:0]       len_q;
  logic [3:0]       beat_q;
  logic             is_write_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic             ready_q;
  logic             last_q;
  logic             proto_err_q;

  logic [IDX_W-1:0] creq_idx;
  logic             ram_en;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_rdata;

  // size and the non-index address bits carry no meaning for this RAM
  logic unused_bits;
  assign unused_bits = ^{cbus.creq.size, cbus.creq.addr};

  assign creq_idx = cbus.creq.addr[2 +: IDX_W];

  // RAM port steering. Reads are issued one cycle ahead of the beat they
  // feed, so the registered RAM output lines up with ready: the last WAIT
  // cycle (or the accepting IDLE cycle when LATENCY is 0) fetches beat 0,
  // and each non-final BURST cycle prefetches the next beat.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = base_q;
    case (state_q)
      IDLE: begin
        if (LATENCY == 0 && cbus.creq.valid && !cbus.creq.is_write) begin
          ram_en   = 1'b1;
          ram_addr = creq_idx;
        end
      end
      WAIT: begin
        if (cbus.creq.valid && lat_cnt_q == LAT_W'(1) && !is_write_q) begin
          ram_en   = 1'b1;
          ram_addr = base_q;
        end
      end
      BURST: begin
        if (cbus.creq.valid) begin
          if (is_write_q) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = base_q + IDX_W'(beat_q);
          end else if (beat_q != len_q) begin
            ram_en   = 1'b1;
            ram_addr = base_q + IDX_W'(beat_q) + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
    // A beat coinciding with reset is abandoned, not committed
    if (reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  cbus_ram_responder_array #(
    .DEPTH (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .en_i     (ram_en),
    .we_i     (ram_we),
    .strobe_i (cbus.creq.strobe),
    .addr_i   (ram_addr),
    .wdata_i  (cbus.creq.data),
    .rdata_o  (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      is_write_q  <= 1'b0;
      lat_cnt_q   <= '0;
      ready_q     <= 1'b0;
      last_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          last_q  <= 1'b0;
          if (cbus.creq.valid) begin
            base_q     <= creq_idx;
            len_q      <= cbus.creq.len;
            is_write_q <= cbus.creq.is_write;
            beat_q     <= 4'd0;
            lat_cnt_q  <= LAT_W'(LATENCY);
            if (LATENCY == 0) begin
              state_q <= BURST;
              ready_q <= 1'b1;
              last_q  <= (cbus.creq.len == MLEN1);
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!cbus.creq.valid) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b1;
          end else if (lat_cnt_q == LAT_W'(1)) begin
            state_q <= BURST;
            ready_q <= 1'b1;
            last_q  <= (len_q == 4'd0);
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        BURST: begin
          if (!cbus.creq.valid) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            last_q      <= 1'b0;
            proto_err_q <= 1'b1;
          end else if (beat_q == len_q) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            beat_q <= beat_q + 4'd1;
            last_q <= ((beat_q + 4'd1) == len_q);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cbus.cresp.ready = ready_q;
  assign cbus.cresp.last  = last_q;
  assign cbus.cresp.data  = ram_rdata;
  assign proto_err        = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cbus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbus_ram_responder
//  Purpose  : Self-checking bench for cbus_ram_responder. The driver issues
//             directed and random transactions, updates a flat word-array
//             memory model and queues the expected beats; a monitor on the
//             falling edge pops one expectation per ready beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cbus_ram_responder;
  import cbus_ram_responder_pkg::*;

  localparam int MEM_WORDS = 4096;
  localparam int LATENCY   = 2;
  localparam int WIN_BASE  = 4064;   // random window: 4064..4095, 0..79
  localparam int WIN_SIZE  = 112;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          last;
  } exp_t;

  logic clk;
  logic reset;
  logic proto_err;

  cbus_ram_responder_if bus ();

  cbus_ram_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cbus      (bus),
    .proto_err (proto_err)
  );

  int          vectors;
  int          miscompares;
  exp_t        exp_q[$];
  bit [31:0]   model_mem [MEM_WORDS];
  logic [31:0] wdata_arr [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one expectation per ready beat
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.cresp.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_last", {31'd0, bus.cresp.last}, {31'd0, e.last});
        if (e.is_read) check("beat_data", bus.cresp.data, e.data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one transaction starting now (1 time unit after a rising edge).
  // drop_at >= 0 deasserts valid during that beat's ready cycle.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input int len,
                        input logic [3:0] strb, input int drop_at);
    int  idx;
    int  beat;
    int  cyc;
    bit  prev_rdy;
    bit  seen_first;
    idx = int'(addr >> 2) % MEM_WORDS;
    for (int b = 0; b <= len; b++) begin
      int mi;
      mi = (idx + b) % MEM_WORDS;
      if (wr) begin
        for (int k = 0; k < 4; k++)
          if (strb[k]) model_mem[mi][8*k +: 8] = wdata_arr[b][8*k +: 8];
      end
      if (drop_at < 0 || b <= drop_at)
        exp_q.push_back('{is_read: !wr, data: model_mem[mi], last: (b == len)});
    end
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = wr;
    bus.creq.size     = cbus_size_e'($urandom_range(0, 3));
    bus.creq.addr     = addr;
    bus.creq.strobe   = strb;
    bus.creq.len      = cbus_len_e'(len[3:0]);
    bus.creq.data     = wdata_arr[0];
    cyc = 0; beat = 0; prev_rdy = 0; seen_first = 0;
    forever begin
      next_cycle();
      cyc++;
      if (prev_rdy) begin
        beat++;
        if (beat > len) break;
        bus.creq.data = wdata_arr[beat];
      end
      prev_rdy = bus.cresp.ready;
      if (prev_rdy && !seen_first) begin
        seen_first = 1;
        check("first_ready_cycle", cyc, LATENCY + 1);
      end
      if (drop_at >= 0 && prev_rdy && beat == drop_at) begin
        bus.creq.valid = 1'b0;
        next_cycle();
        check("drop_ready", {31'd0, bus.cresp.ready}, 32'd0);
        check("drop_proto_err", {31'd0, proto_err}, 32'd1);
        return;
      end
      if (cyc > LATENCY + 40) begin
        check("txn_timeout", cyc, LATENCY + 1);
        bus.creq.valid = 1'b0;
        return;
      end
    end
    bus.creq.valid = 1'b0;
  endtask

  initial begin
    int off;
    int len;
    vectors = 0;
    miscompares = 0;
    bus.creq = '0;
    reset = 1'b1;

    // T1: reset held three cycles
    repeat (3) next_cycle();
    check("rst_ready", {31'd0, bus.cresp.ready}, 32'd0);
    check("rst_last", {31'd0, bus.cresp.last}, 32'd0);
    check("rst_data", bus.cresp.data, 32'd0);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);
    reset = 1'b0;
    next_cycle();

    // T2: single-beat read of word 0x10
    wdata_arr[0] = 32'hDEADBEEF;
    do_txn(1, 32'h40, 0, 4'hF, -1);
    do_txn(0, 32'h40, 0, 4'hF, -1);

    // T3: four-beat write then read back
    for (int i = 0; i < 4; i++) wdata_arr[i] = i + 1;
    do_txn(1, 32'h100, 3, 4'hF, -1);
    do_txn(0, 32'h100, 3, 4'hF, -1);

    // T4: partial-strobe write merge
    wdata_arr[0] = 32'h11223344;
    do_txn(1, 32'h80, 0, 4'hF, -1);
    wdata_arr[0] = 32'hAABBCCDD;
    do_txn(1, 32'h80, 0, 4'b0101, -1);
    do_txn(0, 32'h80, 0, 4'hF, -1);

    // T5: burst wrapping from the top word to word 0
    wdata_arr[0] = 32'hA5A50FFF;
    wdata_arr[1] = 32'h5A5A1000;
    do_txn(1, 32'h3FFC, 1, 4'hF, -1);
    do_txn(0, 32'h3FFC, 1, 4'hF, -1);

    // Fill the random window with known data
    for (int o = 0; o < WIN_SIZE; o += 16) begin
      for (int i = 0; i < 16; i++) wdata_arr[i] = $urandom;
      do_txn(1, 32'(((WIN_BASE + o) % MEM_WORDS) * 4), 15, 4'hF, -1);
    end

    // Random reads/writes inside the window, gap 0..2 idle cycles
    for (int t = 0; t < 250; t++) begin
      off = $urandom_range(0, 95);
      len = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) wdata_arr[i] = $urandom;
      repeat ($urandom_range(0, 2)) next_cycle();
      do_txn($urandom_range(0, 1) == 1, 32'(((WIN_BASE + off) % MEM_WORDS) * 4),
             len, 4'($urandom_range(0, 15)), -1);
    end
    next_cycle();
    check("no_proto_err_after_random", {31'd0, proto_err}, 32'd0);

    // T6: drop valid during beat 2 of a four-beat read
    next_cycle();
    do_txn(0, 32'h100, 3, 4'hF, 2);
    repeat (3) next_cycle();
    check("proto_err_sticky", {31'd0, proto_err}, 32'd1);
    check("ready_idle_after_err", {31'd0, bus.cresp.ready}, 32'd0);

    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("proto_err_cleared", {31'd0, proto_err}, 32'd0);

    // Reset during WAIT: no beat may follow
    bus.creq.valid    = 1'b1;
    bus.creq.is_write = 1'b0;
    bus.creq.addr     = 32'h100;
    bus.creq.len      = MLEN4;
    next_cycle();
    reset = 1'b1;
    bus.creq.valid = 1'b0;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      check("ready_after_wait_reset", {31'd0, bus.cresp.ready}, 32'd0);
    end

    // RAM contents survive the resets
    do_txn(0, 32'h100, 3, 4'hF, -1);
    do_txn(0, 32'h3FFC, 1, 4'hF, -1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) next_cycle();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
